vga_timing_gen: RTL and testbench

- SVGA 800×600@60 Hz raster timing generator, clocked by the 40 MHz pixel clock from the clock manager.
- Produces:
  - Pixel coordinates and a pixel request for the renderer.
  - Registered RGB output with hsync/vsync aligned to it.
  - A per-frame start pulse and a vblank level, so game logic can update state outside the active display.
- Sits between the clock manager and the board VGA connector; the renderer/sprite mixer hangs off `pix_x`/`pix_y`/`rgb_in`.

---
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Summary  : SVGA 800x600@60 raster timing with a two-stage registered
//            RGB/sync pipeline. Define VGA_TEST_PATTERN_EN to replace rgb_in
//            with eight 100-pixel colour bars.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        frame_start,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb_out
);

    localparam int          c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] c_H_LAST   = 11'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [9:0]  c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] c_HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  c_VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic        c_SYNC_ACT = 1'(SYNC_POL);

    logic [10:0] r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_pix_req;
    logic        r_frame_start;
    logic        r_vblank;
    logic        r_de1;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_hsync;
    logic        r_vsync;
    logic [11:0] r_rgb;

    logic [10:0] w_h_nxt;
    logic [9:0]  w_v_nxt;
    logic        w_h_wrap;
    logic        w_hs_act;
    logic        w_vs_act;
    logic [11:0] w_rgb_src;

    always_comb begin
        w_h_wrap = (r_h_cnt == c_H_LAST);
        w_h_nxt  = w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
        w_v_nxt  = r_v_cnt;
        if (w_h_wrap) begin
            w_v_nxt = (r_v_cnt == c_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end
        w_hs_act = (r_h_cnt >= c_HS_BEG) && (r_h_cnt <= c_HS_END);
        w_vs_act = (r_v_cnt >= c_VS_BEG) && (r_v_cnt <= c_VS_END);
    end

`ifdef VGA_TEST_PATTERN_EN
    // x delayed by one stage so the bar colour lines up with de1
    logic [10:0] r_x1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1 <= 11'd0;
        end else begin
            r_x1 <= r_h_cnt;
        end
    end

    always_comb begin
        w_rgb_src = 12'h000;
        if      (r_x1 < 11'd100) w_rgb_src = 12'hFFF;
        else if (r_x1 < 11'd200) w_rgb_src = 12'hFF0;
        else if (r_x1 < 11'd300) w_rgb_src = 12'h0FF;
        else if (r_x1 < 11'd400) w_rgb_src = 12'h0F0;
        else if (r_x1 < 11'd500) w_rgb_src = 12'hF0F;
        else if (r_x1 < 11'd600) w_rgb_src = 12'hF00;
        else if (r_x1 < 11'd700) w_rgb_src = 12'h00F;
        else                     w_rgb_src = 12'h000;
    end
`else
    assign w_rgb_src = rgb_in;
`endif

    // Status flags decode the next counter value so they match pix_x/pix_y
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt       <= c_H_LAST;
            r_v_cnt       <= c_V_LAST;
            r_pix_req     <= 1'b0;
            r_frame_start <= 1'b0;
            r_vblank      <= 1'b0;
            r_de1         <= 1'b0;
            r_hs1         <= ~c_SYNC_ACT;
            r_vs1         <= ~c_SYNC_ACT;
            r_hsync       <= ~c_SYNC_ACT;
            r_vsync       <= ~c_SYNC_ACT;
            r_rgb         <= 12'h000;
        end else begin
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_pix_req     <= (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
            r_frame_start <= (w_h_nxt == 11'd0) && (w_v_nxt == 10'd0);
            r_vblank      <= (w_v_nxt >= c_V_ACT);
            r_de1         <= r_pix_req;
            r_hs1         <= w_hs_act ? c_SYNC_ACT : ~c_SYNC_ACT;
            r_vs1         <= w_vs_act ? c_SYNC_ACT : ~c_SYNC_ACT;
            r_hsync       <= r_hs1;
            r_vsync       <= r_vs1;
            // Mux rather than AND so an X on rgb_in during blanking never leaks
            r_rgb         <= r_de1 ? w_rgb_src : 12'h000;
        end
    end

    assign pix_x       = r_h_cnt;
    assign pix_y       = r_v_cnt;
    assign pix_req     = r_pix_req;
    assign frame_start = r_frame_start;
    assign vblank      = r_vblank;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb_out     = r_rgb;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Summary  : Directed bench: full-size instance for line timing and the data
//            path, a reduced active-low instance for frame/vertical timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    logic        clk;
    logic        rst;
    logic [11:0] rgb_in;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        pix_req, frame_start, vblank, hsync, vsync;
    logic [11:0] rgb_out;

    logic [11:0] rgb_in_s;
    logic [10:0] pix_x_s;
    logic [9:0]  pix_y_s;
    logic        pix_req_s, frame_start_s, vblank_s, hsync_s, vsync_s;
    logic [11:0] rgb_out_s;

    int vectors = 0;
    int fails   = 0;
    int k;
    int mode = 0;
    logic [10:0] x_prev = '0;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in),
        .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
        .frame_start(frame_start), .vblank(vblank),
        .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out)
    );

    // 25 x 10 raster, frame = 250 cycles, active-low syncs
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0)
    ) dut_s (
        .clk(clk), .rst(rst), .rgb_in(rgb_in_s),
        .pix_x(pix_x_s), .pix_y(pix_y_s), .pix_req(pix_req_s),
        .frame_start(frame_start_s), .vblank(vblank_s),
        .hsync(hsync_s), .vsync(vsync_s), .rgb_out(rgb_out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Renderer model: colour for pixel x presented one cycle after x
    always begin
        @(negedge clk);
        x_prev = pix_x;
        @(posedge clk);
        #1;
        case (mode)
            1:       rgb_in = 12'hFFF;
            2:       rgb_in = 12'hxxx;
            default: rgb_in = {x_prev[3:0], 8'h5A};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic adv_to(input int t);
        while (k < t) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        rgb_in   = 12'h000;
        rgb_in_s = 12'hFFF;
        rst      = 1'b1;
        k        = -1;
        repeat (2) @(negedge clk);

        chk("rst_pix_x",   32'(pix_x),   32'd1055);
        chk("rst_pix_y",   32'(pix_y),   32'd627);
        chk("rst_pix_req", 32'(pix_req), 32'd0);
        chk("rst_fstart",  32'(frame_start), 32'd0);
        chk("rst_vblank",  32'(vblank),  32'd0);
        chk("rst_hsync",   32'(hsync),   32'd0);
        chk("rst_vsync",   32'(vsync),   32'd0);
        chk("rst_rgb",     32'(rgb_out), 32'h000);
        chk("rst_s_hsync", 32'(hsync_s), 32'd1);
        chk("rst_s_vsync", 32'(vsync_s), 32'd1);
        chk("rst_s_pix_x", 32'(pix_x_s), 32'd24);

        rst = 1'b0;
        adv_to(0);
        chk("k0_pix_x",   32'(pix_x),   32'd0);
        chk("k0_pix_y",   32'(pix_y),   32'd0);
        chk("k0_pix_req", 32'(pix_req), 32'd1);
        chk("k0_fstart",  32'(frame_start), 32'd1);
        chk("k0_rgb",     32'(rgb_out), 32'h000);
        chk("k0_s_fstart", 32'(frame_start_s), 32'd1);
        adv_to(1);
        chk("k1_fstart",  32'(frame_start), 32'd0);
        adv_to(2);
`ifdef VGA_TEST_PATTERN_EN
        chk("pat_x0", 32'(rgb_out), 32'hFFF);
`else
        chk("rgb_x0", 32'(rgb_out), 32'h05A);
        adv_to(10);
        chk("rgb_x8", 32'(rgb_out), 32'h85A);
`endif
        adv_to(19);
        chk("s_hsync_pre", 32'(hsync_s), 32'd1);
        adv_to(20);
        chk("s_hsync_on",  32'(hsync_s), 32'd0);
        adv_to(24);
        chk("s_hsync_off", 32'(hsync_s), 32'd1);
`ifndef VGA_TEST_PATTERN_EN
        adv_to(25);
        chk("rgb_x23", 32'(rgb_out), 32'h75A);
`endif
        adv_to(127);
        chk("s_rgb_active", 32'(rgb_out_s), 32'hFFF);
        adv_to(149);
        chk("s_vblank_pre", 32'(vblank_s), 32'd0);
        adv_to(150);
        chk("s_vblank_on",  32'(vblank_s), 32'd1);
        chk("s_pix_y6",     32'(pix_y_s),  32'd6);
        adv_to(152);
        chk("s_rgb_blank_y", 32'(rgb_out_s), 32'h000);
`ifdef VGA_TEST_PATTERN_EN
        chk("pat_x150", 32'(rgb_out), 32'hFF0);
`endif
        adv_to(176);
        chk("s_vsync_pre", 32'(vsync_s), 32'd1);
        adv_to(177);
        chk("s_vsync_on",  32'(vsync_s), 32'd0);
        adv_to(226);
        chk("s_vsync_last", 32'(vsync_s), 32'd0);
        adv_to(227);
        chk("s_vsync_off", 32'(vsync_s), 32'd1);
        adv_to(249);
        chk("s_vblank_end", 32'(vblank_s), 32'd1);
        chk("s_fstart_pre", 32'(frame_start_s), 32'd0);
        chk("s_pix_y9",     32'(pix_y_s), 32'd9);
        adv_to(250);
        chk("s_vblank_off", 32'(vblank_s), 32'd0);
        chk("s_fstart_2nd", 32'(frame_start_s), 32'd1);
        chk("s_pix_x_wrap", 32'(pix_x_s), 32'd0);
        chk("s_pix_y_wrap", 32'(pix_y_s), 32'd0);
`ifdef VGA_TEST_PATTERN_EN
        adv_to(752);
        chk("pat_x750", 32'(rgb_out), 32'h000);
`endif
        adv_to(790);
        mode = 1;
        adv_to(799);
        chk("pix_req_799", 32'(pix_req), 32'd1);
        adv_to(800);
        chk("pix_req_800", 32'(pix_req), 32'd0);
`ifndef VGA_TEST_PATTERN_EN
        adv_to(801);
        chk("rgb_x799", 32'(rgb_out), 32'hFFF);
`endif
        adv_to(802);
        chk("rgb_blank_x800", 32'(rgb_out), 32'h000);
        adv_to(803);
        mode = 2;
        adv_to(806);
        chk("rgb_blank_x_in", 32'(rgb_out), 32'h000);
        adv_to(841);
        chk("hsync_pre", 32'(hsync), 32'd0);
        adv_to(842);
        chk("hsync_rise", 32'(hsync), 32'd1);
        adv_to(969);
        chk("hsync_last", 32'(hsync), 32'd1);
        adv_to(970);
        chk("hsync_fall", 32'(hsync), 32'd0);
        adv_to(1000);
        mode = 0;
        adv_to(1055);
        chk("pix_x_1055", 32'(pix_x), 32'd1055);
        chk("pix_y_line0", 32'(pix_y), 32'd0);
        adv_to(1056);
        chk("pix_x_wrap", 32'(pix_x), 32'd0);
        chk("pix_y_line1", 32'(pix_y), 32'd1);
        chk("vblank_line1", 32'(vblank), 32'd0);
        adv_to(1456);
        chk("mid_pix_x", 32'(pix_x), 32'd400);
        chk("mid_pix_req", 32'(pix_req), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
        chk("mid_rgb", 32'(rgb_out), 32'h0F0);
`else
        chk("mid_rgb", 32'(rgb_out), 32'hE5A);
`endif

        // Asynchronous reset mid-line: no clock edge between assert and check
        #1 rst = 1'b1;
        #1;
        chk("arst_pix_x",   32'(pix_x),   32'd1055);
        chk("arst_pix_y",   32'(pix_y),   32'd627);
        chk("arst_pix_req", 32'(pix_req), 32'd0);
        chk("arst_rgb",     32'(rgb_out), 32'h000);
        chk("arst_hsync",   32'(hsync),   32'd0);
        chk("arst_s_vsync", 32'(vsync_s), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        k   = -1;
        adv_to(0);
        chk("rel_pix_x",  32'(pix_x), 32'd0);
        chk("rel_pix_y",  32'(pix_y), 32'd0);
        chk("rel_fstart", 32'(frame_start), 32'd1);
        chk("rel_pix_req", 32'(pix_req), 32'd1);
        adv_to(2);
`ifdef VGA_TEST_PATTERN_EN
        chk("rel_rgb", 32'(rgb_out), 32'hFFF);
`else
        chk("rel_rgb", 32'(rgb_out), 32'h05A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
